// File: rtl/valu_pkg.sv
// Opcodes shared with the packed 4x int8 VALU, plus defaults for the
// accumulate/result stage that sits behind it.
package valu_pkg;

    localparam logic [2:0] OP_VSUM = 3'b010;
    localparam logic [2:0] OP_VSUB = 3'b110;
    localparam logic [2:0] OP_VDP  = 3'b001;

    localparam int MAX_BEATS_DEF = 16;
    localparam int CNT_W_DEF     = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/sat_add32.sv
// Combinational 32-bit signed add that clamps to the int32 range.
module sat_add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        sat
);

    logic [31:0] raw;

    always_comb begin
        raw = a + b;
        // Overflow only when both operands share a sign the result lost.
        sat = (a[31] == b[31]) && (raw[31] != a[31]);
        if (sat) begin
            sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            sum = raw;
        end
    end

endmodule

// File: rtl/valu_acc_stage.sv
// Registered result stage behind the VALU: passes VSUM/VSUB/plain VDP results
// through and accumulates chains of VDP beats into one saturated int32 result.
module valu_acc_stage
    import valu_pkg::*;
#(
    parameter int MAX_BEATS = MAX_BEATS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      v_i,
    input  logic [3:0]       over_i,
    input  logic [2:0]       op_i,
    input  logic             acc_en_i,
    input  logic             last_i,
    input  logic [4:0]       rd_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [31:0]      data_o,
    output logic [3:0]       over_o,
    output logic [4:0]       rd_o,
    output logic             sat_o,
    output logic [CNT_W-1:0] len_o,
    output acc_state_e       state_o
);

    // Handshake: a beat transfers on any edge where valid_i && ready_o, and a
    // result transfers where valid_o && ready_i. Every beat, including ones
    // that only feed the accumulator, needs ready_o; the output payload is
    // frozen while valid_o && !ready_i.

    acc_state_e       state_q, state_d;
    logic [31:0]      acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             acc_sat_q;

    logic             accept;
    logic             is_acc;
    logic             busy;
    logic [31:0]      base;
    logic [CNT_W-1:0] n;
    logic             closing;
    logic             chain_sat;
    logic             emit;
    logic [31:0]      add_sum;
    logic             add_sat;

    assign ready_o = !valid_o || ready_i;
    assign accept  = valid_i && ready_o;
    assign is_acc  = (op_i == OP_VDP) && acc_en_i;
    assign state_o = state_q;

    sat_add32 u_add (
        .a   (base),
        .b   (v_i),
        .sum (add_sum),
        .sat (add_sat)
    );

    // A flush in the same cycle as a beat makes the beat start a fresh chain.
    always_comb begin
        busy      = (state_q == ST_ACC) && !flush_i;
        base      = busy ? acc_q : 32'd0;
        n         = (busy ? cnt_q : '0) + CNT_W'(1);
        closing   = last_i || (n == CNT_W'(MAX_BEATS));
        chain_sat = (busy && acc_sat_q) || add_sat;
        emit      = accept && (!is_acc || closing);
    end

    always_comb begin
        state_d = state_q;
        if (accept && is_acc) begin
            state_d = closing ? ST_IDLE : ST_ACC;
        end else if (flush_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            acc_sat_q <= 1'b0;
        end else if (accept && is_acc && !closing) begin
            acc_q     <= add_sum;
            cnt_q     <= n;
            acc_sat_q <= chain_sat;
        end else if ((accept && is_acc) || flush_i) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            acc_sat_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            over_o  <= '0;
            rd_o    <= '0;
            sat_o   <= 1'b0;
            len_o   <= '0;
        end else if (emit) begin
            valid_o <= 1'b1;
            rd_o    <= rd_i;
            if (is_acc) begin
                data_o <= add_sum;
                over_o <= 4'b0000;
                sat_o  <= chain_sat;
                len_o  <= n;
            end else begin
                data_o <= v_i;
                over_o <= (op_i == OP_VDP) ? 4'b0000 : over_i;
                sat_o  <= 1'b0;
                len_o  <= CNT_W'(1);
            end
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule
